// File: rtl/multicycle_control.sv
// Multi-cycle sequencing controller: steps each instruction through fetch,
// decode, execute, memory and write-back, driving every datapath control.
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             write,
  output logic [4:0]       write_sel,
  output logic             ALUsrc,
  output logic             mem_to_reg,
  output logic [3:0]       ALUControl,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  typedef enum logic [2:0] {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BAD} op_t;

  localparam logic [5:0] OPC_R    = 6'h00;
  localparam logic [5:0] OPC_LW   = 6'h23;
  localparam logic [5:0] OPC_SW   = 6'h2B;
  localparam logic [5:0] OPC_BEQ  = 6'h04;
  localparam logic [5:0] OPC_ADDI = 6'h08;
  localparam logic [5:0] OPC_J    = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  state_t     state;
  op_t        op_q;
  logic [3:0] alu_q;

  op_t        dec_op;
  logic [3:0] dec_alu;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instruction[31:26];
  assign funct         = instruction[5:0];
  assign unused_fields = ^{instruction[25:21], instruction[10:6]};

  // Instruction class and ALU operation, captured once in DECODE so later
  // states do not re-decode.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    dec_op  = OP_BAD;
    dec_alu = ALU_ADD;
    case (opcode)
      OPC_R: begin
        case (funct)
          FN_ADD:  begin dec_op = OP_R; dec_alu = ALU_ADD; end
          FN_SUB:  begin dec_op = OP_R; dec_alu = ALU_SUB; end
          FN_AND:  begin dec_op = OP_R; dec_alu = ALU_AND; end
          FN_OR:   begin dec_op = OP_R; dec_alu = ALU_OR;  end
          FN_SLT:  begin dec_op = OP_R; dec_alu = ALU_SLT; end
          default: dec_op = OP_BAD;
        endcase
      end
      OPC_LW:   dec_op = OP_LW;
      OPC_SW:   dec_op = OP_SW;
      OPC_ADDI: dec_op = OP_ADDI;
      OPC_J:    dec_op = OP_J;
      OPC_BEQ:  begin dec_op = OP_BEQ; dec_alu = ALU_SUB; end
      default:  dec_op = OP_BAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      op_q    <= OP_BAD;
      alu_q   <= ALU_AND;
      retired <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) state <= S_DECODE;
        end
        S_DECODE: begin
          op_q  <= dec_op;
          alu_q <= dec_alu;
          case (dec_op)
            OP_J: begin
              retired <= retired + CNT_W'(1);
              state   <= S_FETCH;
            end
            OP_BAD:  state <= S_FETCH;
            default: state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (op_q)
            OP_BEQ: begin
              retired <= retired + CNT_W'(1);
              state   <= S_FETCH;
            end
            OP_LW, OP_SW: state <= S_MEM;
            default:      state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (op_q == OP_SW) begin
              retired <= retired + CNT_W'(1);
              state   <= S_FETCH;
            end else begin
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          retired <= retired + CNT_W'(1);
          state   <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  // Controls decode from the registered state and instruction; reset forces
  // them low at once so an in-flight memory request is dropped immediately.
  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SEQ;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    write      = 1'b0;
    write_sel  = 5'd0;
    ALUsrc     = 1'b0;
    mem_to_reg = 1'b0;
    ALUControl = 4'b0000;
    illegal    = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_DECODE: begin
          if (dec_op == OP_J) begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
          end
          illegal = (dec_op == OP_BAD);
        end
        S_EXEC: begin
          ALUsrc     = (op_q == OP_R) || (op_q == OP_BEQ);
          ALUControl = alu_q;
          if (op_q == OP_BEQ) begin
            pc_src   = PC_BRANCH;
            pc_write = zero;
          end
        end
        S_MEM: begin
          ALUControl = alu_q;
          iord       = 1'b1;
          mem_read   = (op_q == OP_LW);
          mem_write  = (op_q == OP_SW);
        end
        S_WB: begin
          ALUsrc     = (op_q == OP_R);
          ALUControl = alu_q;
          write      = 1'b1;
          mem_to_reg = (op_q == OP_LW);
          write_sel  = (op_q == OP_R) ? instruction[15:11] : instruction[20:16];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a table of single-instruction vectors
// plus hand-written reset-during-MEM and counter-wrap sequences.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      instruction;
  logic             zero;
  logic             mem_ready;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             write;
  logic [4:0]       write_sel;
  logic             ALUsrc;
  logic             mem_to_reg;
  logic [3:0]       ALUControl;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .instruction(instruction),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .write      (write),
    .write_sel  (write_sel),
    .ALUsrc     (ALUsrc),
    .mem_to_reg (mem_to_reg),
    .ALUControl (ALUControl),
    .illegal    (illegal),
    .retired    (retired)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        z;
    int          mwait;   // mem_ready-low cycles in MEM
    int          cycles;
    int          pcw;     // pc_write pulses, fetch included
    int          psrc;    // pc_src at the last pc_write
    int          wr;
    int          wsel;
    int          m2r;
    int          ill;
    int          mrd;     // data-read request cycles (iord=1)
    int          mwr;     // data-write request cycles (iord=1)
    bit          chk_alu;
    int          alu;
    int          src;
    int          ret;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_ret = 0;
  vec_t vecs[15];

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [31:0] ins, input logic z,
                              input int mw, input int cyc, input int pcw, input int psrc,
                              input int wr, input int wsel, input int m2r, input int ill,
                              input int mrd, input int mwr, input bit ca, input int alu,
                              input int src, input int ret);
    vec_t v;
    v.name = n; v.instr = ins; v.z = z; v.mwait = mw; v.cycles = cyc;
    v.pcw = pcw; v.psrc = psrc; v.wr = wr; v.wsel = wsel; v.m2r = m2r;
    v.ill = ill; v.mrd = mrd; v.mwr = mwr; v.chk_alu = ca; v.alu = alu;
    v.src = src; v.ret = ret;
    return v;
  endfunction

  // Runs one instruction from a FETCH cycle; the cycle after it completes is
  // recognised as the next fetch request and left waiting (mem_ready low).
  task automatic run_instr(input vec_t v);
    int  cyc = 0, irw = 0, pcw = 0, wr = 0, ill = 0, mrd = 0, mwr = 0, bad = 0;
    int  psrc = 0, wsel = 0, m2r = 0, alu_ex = -1, src_ex = -1, alu_wb = -1;
    int  mem_left = v.mwait, fetch_first = 0;
    bit  got_ir = 0, done = 0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      zero      = v.z;
      #1;
      if (k == 1) fetch_first = int'(mem_read && !iord);
      if (got_ir && mem_read && !iord) begin
        done = 1;
        cyc  = k - 1;
      end else begin
        if ((mem_read || mem_write) && iord) begin
          if (mem_left == 0) mem_ready = 1'b1;
          else mem_left--;
        end else if (mem_read) begin
          mem_ready = 1'b1;
        end
        #1;
        if ((mem_read && mem_write) || (write && (mem_read || mem_write))) bad++;
        if (iord && mem_read) mrd++;
        if (iord && mem_write) mwr++;
        if (pc_write) begin pcw++; psrc = int'(pc_src); end
        if (write) begin
          wr++; wsel = int'(write_sel); m2r = int'(mem_to_reg); alu_wb = int'(ALUControl);
        end
        if (illegal) ill++;
        if (k == 3) begin alu_ex = int'(ALUControl); src_ex = int'(ALUsrc); end
        if (ir_write) begin
          irw++;
          got_ir      = 1;
          instruction = v.instr;
        end
      end
    end
    exp_ret = (exp_ret + v.ret) % (1 << CNT_W);
    check({v.name, " completes"}, int'(done), 1);
    check({v.name, " starts in fetch"}, fetch_first, 1);
    check({v.name, " cycles"}, cyc, v.cycles);
    check({v.name, " ir_write pulses"}, irw, 1);
    check({v.name, " pc_write pulses"}, pcw, v.pcw);
    check({v.name, " pc_src"}, psrc, v.psrc);
    check({v.name, " write pulses"}, wr, v.wr);
    check({v.name, " write_sel"}, wsel, v.wsel);
    check({v.name, " mem_to_reg"}, m2r, v.m2r);
    check({v.name, " illegal pulses"}, ill, v.ill);
    check({v.name, " data read cycles"}, mrd, v.mrd);
    check({v.name, " data write cycles"}, mwr, v.mwr);
    check({v.name, " request conflicts"}, bad, 0);
    check({v.name, " retired"}, int'(retired), exp_ret);
    if (v.chk_alu) begin
      check({v.name, " ALUControl exec"}, alu_ex, v.alu);
      check({v.name, " ALUsrc exec"}, src_ex, v.src);
    end
    if (v.wr > 0) check({v.name, " ALUControl wb"}, alu_wb, v.alu);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //              name       instr         z  mw cyc pcw ps wr ws m2r il mrd mwr ca alu      src ret
    vecs[0]  = mk("add",      32'h00221820, 0, 0, 4, 1, 0, 1, 3, 0, 0, 0, 0, 1, 4'b0010, 1, 1);
    vecs[1]  = mk("sub",      32'h00222022, 0, 0, 4, 1, 0, 1, 4, 0, 0, 0, 0, 1, 4'b0110, 1, 1);
    vecs[2]  = mk("and",      32'h00222824, 0, 0, 4, 1, 0, 1, 5, 0, 0, 0, 0, 1, 4'b0000, 1, 1);
    vecs[3]  = mk("or",       32'h00223025, 0, 0, 4, 1, 0, 1, 6, 0, 0, 0, 0, 1, 4'b0001, 1, 1);
    vecs[4]  = mk("slt",      32'h0022382A, 0, 0, 4, 1, 0, 1, 7, 0, 0, 0, 0, 1, 4'b0111, 1, 1);
    vecs[5]  = mk("lw_wait3", 32'h8C250008, 0, 3, 8, 1, 0, 1, 5, 1, 0, 4, 0, 1, 4'b0010, 0, 1);
    vecs[6]  = mk("lw",       32'h8C250008, 0, 0, 5, 1, 0, 1, 5, 1, 0, 1, 0, 1, 4'b0010, 0, 1);
    vecs[7]  = mk("sw",       32'hAC250004, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0010, 0, 1);
    vecs[8]  = mk("sw_wait2", 32'hAC250004, 0, 2, 6, 1, 0, 0, 0, 0, 0, 0, 3, 1, 4'b0010, 0, 1);
    vecs[9]  = mk("addi",     32'h20260005, 0, 0, 4, 1, 0, 1, 6, 0, 0, 0, 0, 1, 4'b0010, 0, 1);
    vecs[10] = mk("beq_taken",32'h10220004, 1, 0, 3, 2, 1, 0, 0, 0, 0, 0, 0, 1, 4'b0110, 1, 1);
    vecs[11] = mk("beq_not",  32'h10220004, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0110, 1, 1);
    vecs[12] = mk("j",        32'h08000000, 0, 0, 2, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0,       0, 1);
    vecs[13] = mk("bad_op",   32'hFC000000, 0, 0, 2, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0,       0, 0);
    vecs[14] = mk("bad_funct",32'h00221803, 0, 0, 2, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0,       0, 0);

    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; instruction = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("reset mem_read", int'(mem_read), 0);
    check("reset ir_write", int'(ir_write), 0);
    check("reset retired", int'(retired), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post-reset fetch mem_read", int'(mem_read), 1);
    check("post-reset fetch iord", int'(iord), 0);

    for (int i = 0; i < 15; i++) run_instr(vecs[i]);

    // Reset asserted while sw waits in MEM.
    @(negedge clk); mem_ready = 1'b1; #1;
    check("sw fetch ir_write", int'(ir_write), 1);
    instruction = 32'hAC250004;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check("sw mem_write before reset", int'(mem_write), 1);
    check("sw iord before reset", int'(iord), 1);
    check("retired before reset", int'(retired), exp_ret);
    #2 reset = 1'b1;
    #1;
    check("mem_write drops on reset", int'(mem_write), 0);
    check("iord drops on reset", int'(iord), 0);
    check("retired cleared on reset", int'(retired), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("fetch resumes mem_read", int'(mem_read), 1);
    check("fetch resumes iord", int'(iord), 0);
    check("fetch resumes no mem_write", int'(mem_write), 0);
    exp_ret = 0;

    // 16 back-to-back jumps with mem_ready held high: counter wraps to 0.
    instruction = 32'h08000000;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); mem_ready = 1'b1; #1;
      check($sformatf("j%0d retired", i), int'(retired), i);
      check($sformatf("j%0d ir_write", i), int'(ir_write), 1);
      @(negedge clk); #1;
      check($sformatf("j%0d pc_write", i), int'(pc_write), 1);
      check($sformatf("j%0d pc_src", i), int'(pc_src), 2);
      check($sformatf("j%0d decode ir_write", i), int'(ir_write), 0);
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    check("retired wrapped", int'(retired), 0);
    check("wrap back in fetch", int'(mem_read && !iord), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
